// File: rtl/sobol_stream_scheduler.sv
// Round-robin scheduler that lends one shared Sobol RNG to NREQ requesters,
// one full-period burst of 2**INWD enabled beats per grant.
module sobol_stream_scheduler #(
    parameter int NREQ = 4,
    parameter int INWD = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            hold,
    input  logic [INWD-1:0] rng_seq,
    output logic            rng_enable,
    output logic [NREQ-1:0] grant,
    output logic            seq_valid,
    output logic [INWD-1:0] seq_out,
    output logic [NREQ-1:0] done,
    output logic            busy
);

    localparam int            PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [INWD:0] LAST_BEAT = (INWD+1)'(2**INWD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [NREQ-1:0] r_done;
    logic [INWD:0]   r_beat_cnt;
    logic [PTR_W-1:0] r_rr_ptr;

    logic             w_found;
    logic [PTR_W-1:0] w_pick;
    logic [PTR_W-1:0] w_next_ptr;
    logic [PTR_W:0]   w_sum;
    logic             w_beat;

    // Search requesters starting at rr_ptr; the first one found wins.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NREQ)) begin
                w_sum = w_sum - (PTR_W+1)'(NREQ);
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[PTR_W-1:0];
            end
        end
    end

    assign w_next_ptr = (w_pick == PTR_W'(NREQ - 1)) ? '0 : w_pick + 1'b1;

    // A beat is any RUN cycle the consumer is not stalling.
    assign w_beat = (r_state == ST_RUN) && !hold;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_done     <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_RUN;
                        r_grant    <= NREQ'(1) << w_pick;
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_beat) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state    <= ST_IDLE;
                            r_grant    <= '0;
                            r_done     <= r_grant;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Enable and valid are combinational so a stall freezes the RNG the same cycle.
    assign rng_enable = w_beat;
    assign seq_valid  = w_beat;
    assign seq_out    = rng_seq;
    assign grant      = r_grant;
    assign done       = r_done;
    assign busy       = (r_state == ST_RUN);

endmodule

// File: tb/tb_sobol_stream_scheduler.sv
// Directed and randomised checks of sobol_stream_scheduler against a 3-bit
// period-8 Sobol RNG model that advances only on rng_enable.
module tb_sobol_stream_scheduler;

    localparam int NREQ = 4;
    localparam int INWD = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic            hold = 1'b0;
    logic [INWD-1:0] rng_seq;
    logic            rng_enable;
    logic [NREQ-1:0] grant;
    logic            seq_valid;
    logic [INWD-1:0] seq_out;
    logic [NREQ-1:0] done;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    // Shared RNG: sequence position advances on each enabled cycle.
    logic [INWD-1:0] sobol_tab [8] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3, 3'd7, 3'd5, 3'd1};
    logic [INWD-1:0] exp_seq   [8] = '{3'd0, 3'd4, 3'd6, 3'd2, 3'd3, 3'd7, 3'd5, 3'd1};
    logic [2:0]      rng_idx;
    logic [NREQ-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int              wait_cnt [NREQ];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          rng_idx <= '0;
        else if (rng_enable) rng_idx <= rng_idx + 1'b1;
    end
    assign rng_seq = sobol_tab[rng_idx];

    always #5 clk = ~clk;

    sobol_stream_scheduler #(.NREQ(NREQ), .INWD(INWD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .hold       (hold),
        .rng_seq    (rng_seq),
        .rng_enable (rng_enable),
        .grant      (grant),
        .seq_valid  (seq_valid),
        .seq_out    (seq_out),
        .done       (done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        hold  = 1'b0;
        step();
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_en", rng_enable, 0);
        check("rst_valid", seq_valid, 0);
        check("rst_seq", seq_out, exp_seq[0]);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Runs one granted burst from its first cycle to the done cycle.
    task automatic run_burst(input string tag, input logic [NREQ-1:0] exp_grant,
                             input int hold_at, input int hold_len, input int drop_at);
        int beats;
        int cyc;
        beats = 0;
        cyc   = 0;
        check({tag, "_grant"}, grant, exp_grant);
        while (busy && cyc < 64) begin
            hold = (cyc >= hold_at) && (cyc < hold_at + hold_len);
            if (cyc == drop_at) req = '0;
            #1;
            check({tag, "_en"}, rng_enable, !hold);
            check({tag, "_valid"}, seq_valid, !hold);
            check({tag, "_grant_run"}, grant, exp_grant);
            check({tag, "_done_run"}, done, 0);
            if (seq_valid) begin
                check({tag, "_seq"}, seq_out, exp_seq[beats % 8]);
                beats++;
            end
            cyc++;
            step();
        end
        hold = 1'b0;
        check({tag, "_beats"}, beats, 8);
        check({tag, "_cycles"}, cyc, 8 + hold_len);
        check({tag, "_done"}, done, exp_grant);
        check({tag, "_grant_idle"}, grant, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_cnt;
        logic [NREQ-1:0] pre_req;
        logic arb;

        // Single requester: grant at T+1, Sobol window, done, re-grant after one bubble.
        do_reset();
        req = 4'b0010;
        check("t1_idle_T", grant, 0);
        step();
        run_burst("t1", 4'b0010, 0, 0, -1);
        step();
        check("t1_regrant", grant, 4'b0010);
        check("t1_done_clear", done, 0);

        // All requesting: strict rotation with exactly one idle cycle between bursts.
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            run_burst("t2", order[k], 0, 0, -1);
            if (k < 4) step();
        end

        // Stall for three cycles mid-burst.
        do_reset();
        req = 4'b0001;
        step();
        run_burst("t3", 4'b0001, 3, 3, -1);

        // Request dropped after the second beat.
        do_reset();
        req = 4'b0100;
        step();
        run_burst("t4", 4'b0100, 0, 0, 2);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_no_grant", grant, 0);
            check("t4_no_busy", busy, 0);
            check("t4_no_done", done, 0);
        end

        // Asynchronous reset at beat 4 aborts the burst; pointer returns to 0.
        do_reset();
        req = 4'b0100;
        step();
        for (int k = 0; k < 4; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_en", rng_enable, 0);
        check("t5_valid", seq_valid, 0);
        check("t5_done", done, 0);
        step();
        check("t5_done_held", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        run_burst("t5", 4'b0001, 0, 0, -1);
        step();
        check("t5_next_rr", grant, 4'b1000);

        // Random traffic: invariants, enables per burst and starvation bound.
        do_reset();
        en_cnt = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            req  = NREQ'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
            #1;
            if (done != 0) begin
                check("t6_en_per_burst", en_cnt, 8);
                en_cnt = 0;
            end
            if (rng_enable) en_cnt++;
            check("t6_onehot0", $onehot0(grant), 1);
            check("t6_grant_iff_busy", grant != 0, busy);
            check("t6_valid_busy", seq_valid && !busy, 0);
            arb     = !busy && (req != 0);
            pre_req = req;
            step();
            if (arb) begin
                check("t6_arb_win", ((grant & pre_req) != 0) && $onehot(grant), 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (pre_req[i] && !grant[i]) wait_cnt[i]++;
                    else                         wait_cnt[i] = 0;
                    check("t6_starve", wait_cnt[i] <= NREQ - 1, 1);
                end
            end
        end
        hold = 1'b0;
        req  = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
